dmem_responder: RTL and testbench

//  Data-memory responder for the MEM stage of the 5-stage MIPS pipeline; serves mem_ren/mem_wen/mem_addr/mem_dout
//  and returns mem_din. Holds a word-addressed RAM with READ_LAT-cycle array access and asserts mem_stall so
//  the hazard unit freezes the pipeline. Flags misaligned/out-of-range accesses. Optional posted write buffer.

---
 rtl/dmem_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word RAM with multi-cycle access, stall/ack handshake
// and a sticky error flag. Define DMEM_WBUF_EN to add a one-entry posted write buffer.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned WRITE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  RdLast = 4'(READ_LAT - 1);
  localparam logic [3:0]  WrLast = 4'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdResp,
    StWrWait,
    StDrainWait
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           din_q, din_d;
  logic                  err_q, err_d;
  logic                  stall, ack;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_widx;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_q [Depth];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req_err;
  logic                  drain_busy;

  assign idx     = mem_addr[ADDR_WIDTH+1:2];
  assign req_err = (mem_ren | mem_wen) &
                   ((mem_addr[1:0] != 2'b00) | (mem_addr[31:ADDR_WIDTH+2] != '0) |
                    (mem_ren & mem_wen));

`ifdef DMEM_WBUF_EN
  localparam logic [3:0] WbLast = 4'(WRITE_LAT);

  logic                  wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0] wb_idx_q, wb_idx_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [3:0]            wb_cnt_q, wb_cnt_d;
  logic                  wb_done;

  assign wb_done    = wb_valid_q & (wb_cnt_q == WbLast);
  assign drain_busy = wb_valid_q & ~wb_done;
`else
  assign drain_busy = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    err_d     = err_q;
    stall     = 1'b0;
    ack       = 1'b0;
    ram_we    = 1'b0;
    ram_widx  = idx;
    ram_wdata = mem_dout;
`ifdef DMEM_WBUF_EN
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    wb_cnt_d   = wb_cnt_q;
    // Background drain: the buffered word lands in the RAM on its WRITE_LAT-th cycle.
    if (wb_valid_q) begin
      if (wb_done) begin
        ram_we     = 1'b1;
        ram_widx   = wb_idx_q;
        ram_wdata  = wb_data_q;
        wb_valid_d = 1'b0;
      end else begin
        wb_cnt_d = wb_cnt_q + 4'd1;
      end
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (req_err) begin
          ack   = 1'b1;
          din_d = '0;
          err_d = 1'b1;
        end else if (mem_ren) begin
`ifdef DMEM_WBUF_EN
          if (wb_valid_q && (wb_idx_q == idx)) begin
            ack   = 1'b1;
            din_d = wb_data_q;
          end else if (wb_valid_q) begin
            stall   = 1'b1;
            state_d = StDrainWait;
          end else
`endif
          begin
            stall = 1'b1;
            cnt_d = 4'd1;
            if (READ_LAT == 1) begin
              din_d   = ram_q[idx];
              state_d = StRdResp;
            end else begin
              state_d = StRdWait;
            end
          end
        end else if (mem_wen) begin
`ifdef DMEM_WBUF_EN
          if (wb_valid_q) begin
            stall   = 1'b1;
            state_d = StDrainWait;
          end else begin
            ack        = 1'b1;
            wb_valid_d = 1'b1;
            wb_idx_d   = idx;
            wb_data_d  = mem_dout;
            wb_cnt_d   = 4'd1;
          end
`else
          if (WRITE_LAT == 1) begin
            ack    = 1'b1;
            ram_we = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = 4'd1;
            state_d = StWrWait;
          end
`endif
        end
      end
      StRdWait: begin
        stall = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == RdLast) begin
          din_d   = ram_q[idx];
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        // The request is still held this cycle; it is deliberately not re-sampled.
        ack     = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      StWrWait: begin
        if (cnt_q == WrLast) begin
          ack     = 1'b1;
          ram_we  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDrainWait: begin
        stall = 1'b1;
        if (!drain_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!rst_n) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_WBUF_EN
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      err_q   <= err_d;
`ifdef DMEM_WBUF_EN
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_cnt_q   <= wb_cnt_d;
`endif
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_widx] <= ram_wdata;
    end
  end

  assign mem_din   = din_q;
  assign mem_err   = err_q;
  assign mem_stall = stall & rst_n;
  assign mem_ack   = ack & rst_n;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a word-level memory model feeds a queue of expected read data
// that is popped when the responder acknowledges. Covers the DMEM_WBUF_EN build when it is defined.
module tb_dmem_responder;

  logic        clk, rst_n, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall, mem_ack, mem_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [int];

  localparam int RdStall = 2;
`ifdef DMEM_WBUF_EN
  localparam int WrStall = 0;
`else
  localparam int WrStall = 1;
`endif

  dmem_responder #(
    .ADDR_WIDTH(10),
    .READ_LAT  (2),
    .WRITE_LAT (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_stall(mem_stall),
    .mem_ack  (mem_ack),
    .mem_err  (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request; late=1 when read data is loaded on the acknowledging edge (error or forward).
  task automatic access(input string tag, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int exp_stall, input bit late);
    int          stalls;
    bit          is_err;
    logic [31:0] want;
    stalls = 0;
    is_err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'h0) || (ren && wen);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = data;
    if (is_err) exp_q.push_back(32'h0);
    else if (ren) exp_q.push_back(model[int'(addr[11:2])]);
    else model[int'(addr[11:2])] = data;
    @(negedge clk);
    while (mem_stall && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    check({tag, " stalls"}, 32'(stalls), 32'(exp_stall));
    check({tag, " ack"}, {31'b0, mem_ack}, 32'h1);
    if (ren && !is_err && !late) begin
      want = exp_q.pop_front();
      check({tag, " din"}, mem_din, want);
    end
    @(posedge clk);
    #1;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    #1;
    check({tag, " ack pulse"}, {31'b0, mem_ack}, 32'h0);
    if (is_err || (ren && late)) begin
      want = exp_q.pop_front();
      check({tag, " din"}, mem_din, want);
    end
    if (is_err) check({tag, " err"}, {31'b0, mem_err}, 32'h1);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    #3;
    check("reset stall", {31'b0, mem_stall}, 32'h0);
    check("reset ack", {31'b0, mem_ack}, 32'h0);
    check("reset din", mem_din, 32'h0);
    check("reset err", {31'b0, mem_err}, 32'h0);
    #10 rst_n = 1'b1;
    idle(1);

    access("wr 10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, WrStall, 1'b0);
    idle(4);
    access("rd 10", 1'b1, 1'b0, 32'h10, 32'h0, RdStall, 1'b0);
    access("wr 20", 1'b0, 1'b1, 32'h20, 32'h1234_5678, WrStall, 1'b0);
    idle(4);
    access("rd 20", 1'b1, 1'b0, 32'h20, 32'h0, RdStall, 1'b0);
    idle(3);
    check("idle hold din", mem_din, 32'h1234_5678);
    access("b2b rd 10", 1'b1, 1'b0, 32'h10, 32'h0, RdStall, 1'b0);
    access("b2b rd 20", 1'b1, 1'b0, 32'h20, 32'h0, RdStall, 1'b0);
    access("wr 30", 1'b0, 1'b1, 32'h30, 32'h1111_1111, WrStall, 1'b0);
    idle(4);

    // Reset in the middle of a read wait.
    access("err pre rst", 1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b1);
    access("rd pre rst", 1'b1, 1'b0, 32'h10, 32'h0, RdStall, 1'b0);
    mem_ren  = 1'b1;
    mem_addr = 32'h20;
    @(posedge clk);
    #1;
    check("mid rd stall", {31'b0, mem_stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid rst stall", {31'b0, mem_stall}, 32'h0);
    check("mid rst ack", {31'b0, mem_ack}, 32'h0);
    check("mid rst din", mem_din, 32'h0);
    check("mid rst err", {31'b0, mem_err}, 32'h0);
    mem_ren = 1'b0;
    #1 rst_n = 1'b1;
    idle(1);

    // A write cut off by reset must leave the RAM word untouched.
    mem_wen  = 1'b1;
    mem_addr = 32'h30;
    mem_dout = 32'h2222_2222;
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    mem_wen = 1'b0;
    #2 rst_n = 1'b1;
    idle(4);
    access("rd 30 after abort", 1'b1, 1'b0, 32'h30, 32'h0, RdStall, 1'b0);
    access("rd 10 after rst", 1'b1, 1'b0, 32'h10, 32'h0, RdStall, 1'b0);

    // Error requests and stickiness.
    access("err misalign", 1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b1);
    access("good rd", 1'b1, 1'b0, 32'h20, 32'h0, RdStall, 1'b0);
    access("good wr", 1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, WrStall, 1'b0);
    idle(4);
    check("err sticky", {31'b0, mem_err}, 32'h1);
    access("err ren wen", 1'b1, 1'b1, 32'h10, 32'h5555_5555, 0, 1'b1);
    access("err range", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, 1'b1);
    access("err wr misalign", 1'b0, 1'b1, 32'h22, 32'h7777_7777, 0, 1'b1);
    idle(4);
    access("rd 20 unharmed", 1'b1, 1'b0, 32'h20, 32'h0, RdStall, 1'b0);
    access("rd 10 unharmed", 1'b1, 1'b0, 32'h10, 32'h0, RdStall, 1'b0);
    access("rd 24", 1'b1, 1'b0, 32'h24, 32'h0, RdStall, 1'b0);

`ifdef DMEM_WBUF_EN
    access("wb wr 40", 1'b0, 1'b1, 32'h40, 32'hA5A5_A5A5, 0, 1'b0);
    access("wb fwd 40", 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b1);
    idle(4);
    access("wb wr 40b", 1'b0, 1'b1, 32'h40, 32'hA5A5_A5A5, 0, 1'b0);
    access("wb wr 44 conflict", 1'b0, 1'b1, 32'h44, 32'h5A5A_1234, 2, 1'b0);
    idle(4);
    access("wb rd 40", 1'b1, 1'b0, 32'h40, 32'h0, RdStall, 1'b0);
    access("wb rd 44", 1'b1, 1'b0, 32'h44, 32'h0, RdStall, 1'b0);
    access("wb wr 50", 1'b0, 1'b1, 32'h50, 32'h0BAD_CAFE, 0, 1'b0);
    access("wb rd miss", 1'b1, 1'b0, 32'h10, 32'h0, 4, 1'b0);
    idle(4);
    access("wb rd 50", 1'b1, 1'b0, 32'h50, 32'h0, RdStall, 1'b0);
`endif

    check("scoreboard empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
